// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-stage access controller.
// State encoding, op codes and default timeout.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory access controller.
// Expires when the count reaches TIMEOUT-1.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: one handshaked request per load/store,
// pipeline stall until completion, sticky error and halt dump pulse.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] writeData,
  input  logic          memRead,
  input  logic          memWrite,
  input  logic          halt,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic          mem_busy,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_err,
  output logic [DW-1:0] readData,
  output logic          stall,
  output logic          dump,
  output logic          err
);

  state_t state;
  op_t    op;
  logic   halt_seen;
  logic   legal;
  logic   illegal;
  logic   fire;
  logic   t_expired;

  assign legal   = (memRead ^ memWrite) && !addr[0];
  assign illegal = (memRead || memWrite) && !legal;
  assign fire    = (state == IDLE) && halt && !memRead
                   && !memWrite && !halt_seen;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == REQ),
    .en      (state == WAIT),
    .expired (t_expired)
  );

  assign mem_rd = (state == REQ) && (op == OP_RD);
  assign mem_wr = (state == REQ) && (op == OP_WR);

  // Illegal accesses pass through unstalled as no-ops.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE:     stall = legal;
        REQ:      stall = 1'b1;
        WAIT:     stall = 1'b1;
        default:  stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= OP_RD;
      mem_addr  <= '0;
      mem_wdata <= '0;
      readData  <= '0;
      dump      <= 1'b0;
      err       <= 1'b0;
      halt_seen <= 1'b0;
    end else begin
      dump <= fire;
      if (!halt) begin
        halt_seen <= 1'b0;
      end else if (fire) begin
        halt_seen <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (legal) begin
            mem_addr  <= addr;
            mem_wdata <= writeData;
            op        <= memWrite ? OP_WR : OP_RD;
            state     <= REQ;
          end else if (illegal) begin
            err <= 1'b1;
          end
        end
        REQ: begin
          if (!mem_busy) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Completion takes priority over a same-cycle timeout.
          if (mem_done) begin
            if (op == OP_RD) begin
              readData <= mem_rdata;
            end
            if (mem_err) begin
              err <= 1'b1;
            end
            state <= RESP;
          end else if (t_expired) begin
            err   <= 1'b1;
            state <= RESP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a read-data scoreboard.
// Inputs change 1ns after posedge; outputs sampled 2ns later.
module tb_mem_access_ctrl;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic        halt;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_busy;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        mem_err;
  logic [15:0] readData;
  logic        stall;
  logic        dump;
  logic        err;

  int checks;
  int errors;
  logic [15:0] exp_q[$];

  mem_access_ctrl #(
    .TIMEOUT (TO),
    .AW      (16),
    .DW      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .writeData (writeData),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .halt      (halt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .readData  (readData),
    .stall     (stall),
    .dump      (dump),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, readData, e);
    end
  endtask

  int sc;
  int rc;
  int wc;
  int dc;
  int dfirst;
  logic [15:0] wd_seen;
  logic [15:0] wa_seen;
  logic s_resp;
  logic e_pre;
  logic e_post;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    addr = '0;
    writeData = '0;
    memRead = 1'b0;
    memWrite = 1'b0;
    halt = 1'b0;
    mem_busy = 1'b0;
    mem_done = 1'b0;
    mem_rdata = '0;
    mem_err = 1'b0;

    // Reset values, with a load presented during reset
    #12;
    memRead = 1'b1;
    addr = 16'h0040;
    #1;
    check("rst_stall", stall, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_readData", readData, 0);
    check("rst_err", err, 0);
    check("rst_dump", dump, 0);
    next();
    rst = 1'b0;
    memRead = 1'b0;
    next();

    // T1: load 0x0040, done in first WAIT cycle
    sc = 0; rc = 0;
    exp_q.push_back(16'hBEEF);
    for (int i = 0; i < 6; i++) begin
      memRead = (i < 4);
      addr = 16'h0040;
      mem_done = (i == 2);
      mem_rdata = 16'hBEEF;
      #2;
      if (stall) sc++;
      if (mem_rd) rc++;
      next();
    end
    mem_done = 1'b0;
    check("t1_rd_cycles", rc, 1);
    check("t1_stall_cycles", sc, 3);
    sb_check("t1_readData");
    check("t1_err", err, 0);

    // T2: store 0x0010 with mem_busy for two cycles
    sc = 0; wc = 0; s_resp = 1'b1;
    wd_seen = '0; wa_seen = '0;
    exp_q.push_back(16'hBEEF);
    for (int i = 0; i < 8; i++) begin
      memWrite = (i < 6);
      addr = 16'h0010;
      writeData = 16'h1234;
      mem_busy = (i == 1) || (i == 2);
      mem_done = (i == 4);
      mem_rdata = 16'hFFFF;
      #2;
      if (stall) sc++;
      if (mem_wr) begin
        wc++;
        wd_seen = mem_wdata;
        wa_seen = mem_addr;
      end
      if (i == 5) s_resp = stall;
      next();
    end
    mem_busy = 1'b0;
    mem_done = 1'b0;
    check("t2_wr_cycles", wc, 3);
    check("t2_wdata", wd_seen, 16'h1234);
    check("t2_waddr", wa_seen, 16'h0010);
    check("t2_stall_cycles", sc, 5);
    check("t2_resp_stall", s_resp, 0);
    sb_check("t2_readData");

    // T3: misaligned load, then read+write together
    memRead = 1'b1;
    addr = 16'h0041;
    #2;
    check("t3_mis_stall", stall, 0);
    check("t3_mis_rd", mem_rd, 0);
    next();
    memRead = 1'b0;
    #2;
    check("t3_err_set", err, 1);
    check("t3_no_req", mem_rd, 0);
    next();
    memRead = 1'b1;
    memWrite = 1'b1;
    addr = 16'h0020;
    #2;
    check("t3_rw_stall", stall, 0);
    next();
    memRead = 1'b0;
    memWrite = 1'b0;
    #2;
    check("t3_rw_strobes", {mem_rd, mem_wr}, 0);
    check("t3_err_sticky", err, 1);
    next();

    // T5: reset during WAIT, late mem_done ignored
    memRead = 1'b1;
    addr = 16'h0040;
    next();
    next();
    #2;
    check("t5_wait_stall", stall, 1);
    rst = 1'b1;
    #1;
    check("t5_async_stall", stall, 0);
    check("t5_async_rd", mem_rd, 0);
    check("t5_readData", readData, 0);
    check("t5_err_cleared", err, 0);
    next();
    rst = 1'b0;
    memRead = 1'b0;
    next();
    next();
    mem_done = 1'b1;
    mem_rdata = 16'hDEAD;
    #2;
    check("t5_late_stall", stall, 0);
    next();
    mem_done = 1'b0;
    #2;
    exp_q.push_back(16'h0000);
    sb_check("t5_late_readData");
    check("t5_late_err", err, 0);
    next();

    // T4a: mem_done in the last WAIT cycle beats timeout
    sc = 0;
    exp_q.push_back(16'h5A5A);
    for (int i = 0; i < 21; i++) begin
      memRead = (i <= 18);
      addr = 16'h0080;
      mem_done = (i == TO + 1);
      mem_rdata = 16'h5A5A;
      #2;
      if (stall) sc++;
      next();
    end
    mem_done = 1'b0;
    check("t4a_stall_cycles", sc, TO + 2);
    check("t4a_err", err, 0);
    sb_check("t4a_readData");

    // T4b: timeout with no mem_done
    sc = 0; s_resp = 1'b1; e_pre = 1'b1; e_post = 1'b0;
    exp_q.push_back(16'h5A5A);
    for (int i = 0; i < 21; i++) begin
      memRead = (i <= TO + 2);
      addr = 16'h0082;
      #2;
      if (stall) sc++;
      if (i == TO + 1) e_pre = err;
      if (i == TO + 2) s_resp = stall;
      if (i == TO + 3) e_post = err;
      next();
    end
    check("t4b_stall_cycles", sc, TO + 2);
    check("t4b_err_before", e_pre, 0);
    check("t4b_resp_stall", s_resp, 0);
    check("t4b_err_after", e_post, 1);
    sb_check("t4b_readData");

    // T6: halt with load pending, dump after completion only once
    dc = 0; dfirst = -1;
    exp_q.push_back(16'h7777);
    for (int i = 0; i < 10; i++) begin
      halt = 1'b1;
      memRead = (i < 4);
      addr = 16'h0042;
      mem_done = (i == 2);
      mem_rdata = 16'h7777;
      #2;
      if (dump) begin
        dc++;
        if (dfirst < 0) dfirst = i;
      end
      next();
    end
    mem_done = 1'b0;
    check("t6_dump_count", dc, 1);
    check("t6_dump_after", (dfirst > 3) && (dfirst <= 5), 1);
    sb_check("t6_readData");

    // T6b: rearm after halt drops
    halt = 1'b0;
    next();
    dc = 0;
    for (int i = 0; i < 4; i++) begin
      halt = 1'b1;
      #2;
      if (dump) dc++;
      next();
    end
    check("t6b_rearm", dc, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
